// File: rtl/uart_transmitter.sv
// uart_transmitter
//   UART serialiser between a first-word-fall-through TX FIFO and the serial
//   pin. It pops one word, then sends a start bit, SIZE_DATA data bits (LSB
//   first) and a stop bit. Each bit lasts OVER_SAMPLE ticks of i_stick, the
//   baud tick that the receiver also uses.
//
//   Optional feature: define UART_TX_PARITY_EN to insert a parity bit between
//   the last data bit and the stop bit. Its sense is set by PARITY_ODD
//   (0 = even, 1 = odd). PARITY_ODD is ignored when the macro is undefined.
//
// Ports
//   i_clk         system clock
//   i_rst         asynchronous, active-high reset
//   i_stick       baud tick, one i_clk cycle wide, OVER_SAMPLE ticks per bit
//   i_tx_en       transmit enable, sampled only while idle
//   i_fifo_empty  TX FIFO empty flag
//   i_tx_data     FIFO head word, valid while i_fifo_empty = 0
//   o_fifo_rd     FIFO pop strobe, one cycle per frame
//   o_tx_serial   serial line, idle high
//   o_tx_busy     frame in progress
//   o_tx_done     one-cycle pulse when the stop bit ends
module uart_transmitter #(
  parameter int SIZE_DATA   = 16,
  parameter int OVER_SAMPLE = 16,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stick,
  input  logic                 i_tx_en,
  input  logic                 i_fifo_empty,
  input  logic [SIZE_DATA-1:0] i_tx_data,
  output logic                 o_fifo_rd,
  output logic                 o_tx_serial,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  localparam int CNT_W = $clog2(OVER_SAMPLE) + 1;
  localparam int IDX_W = (SIZE_DATA > 1) ? $clog2(SIZE_DATA) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [IDX_W-1:0]     index_q, index_d;
  logic [SIZE_DATA-1:0] shift_q, shift_d;
  logic                 tx_serial_q, tx_serial_d;
  logic                 fifo_rd_q, fifo_rd_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic bit_end;

  assign bit_end = i_stick && (count_q == CNT_W'(OVER_SAMPLE - 1));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    index_d   = index_q;
    shift_d   = shift_q;
    fifo_rd_d = 1'b0;
    tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    // The bit-period counter runs only while a frame is on the line.
    if (state_q != ST_IDLE && i_stick) begin
      count_d = bit_end ? '0 : count_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        // Leaving idle does not wait for a tick: the start bit is timed
        // from the first tick after the pop.
        if (i_tx_en && !i_fifo_empty) begin
          fifo_rd_d = 1'b1;
          shift_d   = i_tx_data;
          count_d   = '0;
          index_d   = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = (^i_tx_data) ^ PARITY_ODD;
`endif
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          index_d = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (index_q == IDX_W'(SIZE_DATA - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            index_d = index_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          tx_done_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are computed from the next state so that the registered line,
    // busy flag and strobes all change on the same edge as the state.
    tx_serial_d = 1'b1;
    unique case (state_d)
      ST_IDLE:   tx_serial_d = 1'b1;
      ST_START:  tx_serial_d = 1'b0;
      ST_DATA:   tx_serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_serial_d = parity_d;
`endif
      ST_STOP:   tx_serial_d = 1'b1;
      default:   tx_serial_d = 1'b1;
    endcase
    tx_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      index_q     <= '0;
      shift_q     <= '0;
      tx_serial_q <= 1'b1;
      fifo_rd_q   <= 1'b0;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      index_q     <= index_d;
      shift_q     <= shift_d;
      tx_serial_q <= tx_serial_d;
      fifo_rd_q   <= fifo_rd_d;
      tx_busy_q   <= tx_busy_d;
      tx_done_q   <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign o_fifo_rd   = fifo_rd_q;
  assign o_tx_serial = tx_serial_q;
  assign o_tx_busy   = tx_busy_q;
  assign o_tx_done   = tx_done_q;

endmodule
